cam_frame_ctrl: RTL and testbench
=================================

# cam_frame_ctrl

Capture controller between the CameraLink-to-AXI4-Stream receiver output and the downstream video consumer (VDMA or frame buffer). Gates the pixel stream on frame boundaries under software control: single-shot, N-frame or continuous capture, always starting on a start-of-frame beat and always stopping on a completed frame. Counts pixels and lines against a configured geometry, flags malformed frames and keeps the upstream FIFO drained while capture is idle.

## Interface
- DATA_WIDTH, 24, pixel bus width (R-B-G packed)
- USER_WIDTH, 1, tuser width; bit 0 is start-of-frame
- CNT_WIDTH, 12, pixel/line counter and geometry width
- FRM_WIDTH, 16, frame counter and ctrl_nframes width

Ports:
- aclk  in  1  sole clock
- areset  in  1  reset, synchronous, active-high
- s_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/USER_WIDTH  stream from receiver
- m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  same widths  gated stream to consumer
- ctrl_start  in  1  one-cycle pulse; arms capture
- ctrl_stop  in  1  one-cycle pulse; graceful stop
- ctrl_mode  in  2  0 single, 1 N-frame, 2 continuous, 3 reserved (treated as single); sampled on ctrl_start
- ctrl_nframes  in  FRM_WIDTH  frame count for N-frame mode; sampled on ctrl_start
- cfg_width, cfg_height  in  CNT_WIDTH each  pixels per line, lines per frame; sampled on ctrl_start
- busy  out  1  high when not IDLE
- frame_done  out  1  one-cycle pulse per completed frame
- frame_count  out  FRM_WIDTH  completed frames since last start
- err_short_line, err_long_line, err_early_sof  out  1 each  sticky error flags

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE: s_axis_tready=1, m_axis_tvalid=0. All beats are discarded. ctrl_start goes to ARMED, latches the config, and clears frame_count and error flags.
- ARMED: non-SOF beats are discarded (tready=1). SOF beat (tuser[0]=1): m_axis_tvalid=s_axis_tvalid and s_axis_tready=m_axis_tready. When that beat handshakes, go to CAPTURE with pixel count 1 and line count 0. ctrl_stop returns to IDLE immediately.
- CAPTURE: full pass-through; m_axis_tvalid=s_axis_tvalid and s_axis_tready=m_axis_tready.
- Counting uses forwarded handshakes only:
  - pix_cnt increments per beat.
  - On tlast, pix_cnt clears and line_cnt increments.
  - A tlast beat with line_cnt==cfg_height-1 ends the frame: frame_count++ (wraps) and frame_done pulses.
- At frame end:
  - Single mode goes to IDLE.
  - N-frame mode goes to IDLE when frame_count reaches ctrl_nframes; ctrl_nframes=0 is treated as 1.
  - Continuous mode stays in CAPTURE, expecting the next SOF.
  - If a stop is pending, go to IDLE.
- ctrl_stop in CAPTURE sets stop_pending; the current frame completes first. stop_pending clears on entry to IDLE.
- ctrl_start outside IDLE is ignored. ctrl_start and ctrl_stop in the same cycle: stop wins, start is ignored.
- cfg_width or cfg_height of 0 is treated as 1.
- tdata, tlast and tuser pass through unmodified in every state.

## Timing
- Data path has zero latency, purely combinational: tdata/tlast/tuser/tvalid forward, tready backward. No AXIS register slice.
- State, counters, flags and frame_done are registered. frame_done asserts the cycle after the final tlast handshake.
- While areset is high: s_axis_tready=0, m_axis_tvalid=0. After reset: state IDLE, busy=0, frame_done=0, frame_count=0, all error flags 0, stop_pending=0, counters 0.
- Reset mid-frame abandons the frame immediately. No tlast is synthesized.
- busy is registered from state.
- Counters are CNT_WIDTH wide and saturate, never wrap. A line longer than 2^CNT_WIDTH-1 is reported only through err_long_line.

## Configuration
- CAM_FRAME_CTRL_GEOM_CHECK_EN defined: geometry checks are active.
  - err_short_line sets on tlast with pix_cnt+1 < cfg_width.
  - err_long_line sets on a non-tlast beat with pix_cnt+1 == cfg_width.
  - err_early_sof sets on a SOF beat in CAPTURE while pix_cnt or line_cnt is non-zero. Counters restart at that beat (pix_cnt=1, line_cnt=0) and the aborted frame is not counted.
- Not defined: the three flags are tied to 0. A mid-frame SOF has no effect on the counters; frame end is purely by line count.

## Structure
- Package cam_ctrl_pkg holds:
  - state enum (IDLE, ARMED, CAPTURE)
  - ctrl_mode encodings (MODE_SINGLE=0, MODE_NFRAME=1, MODE_CONT=2)
  - SOF bit index constant (0)
- One sub-module, cam_geom_counter: pix_cnt/line_cnt, end-of-frame detect and macro-guarded error logic. Inputs are beat/tlast/tuser/cfg. Outputs are eof, sof_restart and error strobes.
- Gating, the FSM and the frame counter stay in cam_frame_ctrl.

## Test plan
- Single mode, cfg 4x3. Start mid-frame, then a full 4x3 frame. Expected: beats before SOF are dropped with s_axis_tready=1; exactly 12 beats are forwarded, first with tuser=1; frame_done pulses once; frame_count=1; back to IDLE.
- N-frame mode, nframes=3, 2x2 frames, m_axis_tready toggling 1/0 each cycle. Expected: 3 frames forwarded intact; s_axis_tready mirrors m_axis_tready in CAPTURE; frame_count=3; IDLE.
- Continuous mode, ctrl_stop on pixel 2 of line 1 in a 4x3 frame. Expected: the frame completes (12 beats), then IDLE; the next SOF is not forwarded.
- With macro, cfg 4x2: line 0 of 3 beats, then line 1 of 5 beats, then an SOF at pixel 2. Expected: err_short_line=1, err_long_line=1, err_early_sof=1; counters restart; no frame_done for the aborted frame.
- areset asserted mid-line in CAPTURE. Expected: next cycle IDLE, busy=0, frame_count=0, flags 0; s_axis_tready=0 while reset is held, 1 after release.
- ctrl_start and ctrl_stop in the same cycle in IDLE. Expected: stays IDLE, busy=0. ctrl_stop in ARMED: IDLE next cycle.

Source files
------------

// File: rtl/cam_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cam_ctrl_pkg
// Shared types and constants for the camera frame capture controller:
//   - state_e      : controller state (IDLE, ARMED, CAPTURE)
//   - MODE_*       : ctrl_mode encodings (3 is reserved and behaves as single)
//   - SOF_BIT      : tuser bit that marks start-of-frame
//   - norm_mode()  : folds the reserved mode encoding onto single-shot
// ----------------------------------------------------------------------------
package cam_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_NFRAME = 2'd1;
  localparam logic [1:0] MODE_CONT   = 2'd2;

  localparam int SOF_BIT = 0;

  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == MODE_NFRAME || mode == MODE_CONT) ? mode : MODE_SINGLE;
  endfunction

endpackage

// File: rtl/cam_frame_ctrl_if.sv
// ----------------------------------------------------------------------------
// cam_frame_ctrl_if
// AXI4-Stream video beat bundle used on both sides of cam_frame_ctrl.
//   tdata  : pixel (DATA_WIDTH)        tvalid : beat valid
//   tready : sink ready (backwards)    tlast  : end of line
//   tuser  : sideband, bit SOF_BIT marks start-of-frame (USER_WIDTH)
// Modports: master drives the beat and samples tready; slave the reverse.
// ----------------------------------------------------------------------------
interface cam_frame_ctrl_if #(
  parameter int DATA_WIDTH = 24,
  parameter int USER_WIDTH = 1
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, output tvalid, input tready, output tlast, output tuser);
  modport slave  (input tdata, input tvalid, output tready, input tlast, input tuser);

endinterface

// File: rtl/cam_geom_counter.sv
// ----------------------------------------------------------------------------
// cam_geom_counter
// Pixel/line position tracker for the forwarded stream. Detects end of frame
// from the line count and, when CAM_FRAME_CTRL_GEOM_CHECK_EN is defined,
// raises per-beat strobes for short lines, long lines and early SOF (the
// latter also restarts the counters at the offending beat).
// Ports:
//   aclk, areset       : clock, synchronous active-high reset
//   i_clear            : zero the counters (capture being armed)
//   i_beat             : a beat was forwarded this cycle
//   i_tlast, i_sof     : tlast / start-of-frame of that beat
//   i_first            : beat is the frame-opening SOF accepted while armed
//   i_width, i_height  : geometry, already forced to be non-zero
//   o_eof              : this beat completes the frame
//   o_sof_restart      : counters restarted on a mid-frame SOF
//   o_err_short/long/early : error strobes (always 0 without the macro)
// ----------------------------------------------------------------------------
module cam_geom_counter
  import cam_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 12
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 i_clear,
  input  logic                 i_beat,
  input  logic                 i_tlast,
  input  logic                 i_sof,
  input  logic                 i_first,
  input  logic [CNT_WIDTH-1:0] i_width,
  input  logic [CNT_WIDTH-1:0] i_height,
  output logic                 o_eof,
  output logic                 o_sof_restart,
  output logic                 o_err_short,
  output logic                 o_err_long,
  output logic                 o_err_early
);

`ifdef CAM_FRAME_CTRL_GEOM_CHECK_EN
  localparam bit GEOM_CHECK = 1'b1;
`else
  localparam bit GEOM_CHECK = 1'b0;
`endif

  logic [CNT_WIDTH-1:0] r_pix;
  logic [CNT_WIDTH-1:0] r_line;
  logic [CNT_WIDTH-1:0] w_pix_base;
  logic [CNT_WIDTH-1:0] w_line_base;
  logic [CNT_WIDTH:0]   w_pix_inc;
  logic                 w_mid_frame;
  logic                 w_restart;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_mid_frame   = (r_pix != '0) || (r_line != '0);
  assign o_err_early   = GEOM_CHECK & i_beat & i_sof & ~i_first & w_mid_frame;
  assign o_sof_restart = o_err_early;

  // The frame-opening SOF and a mid-frame SOF both count from a clean origin,
  // so everything below works on the "base" position this beat is counted from.
  assign w_restart   = i_first | o_sof_restart;
  assign w_pix_base  = w_restart ? '0 : r_pix;
  assign w_line_base = w_restart ? '0 : r_line;

  // One bit wider so the +1 never wraps when the count is saturated.
  assign w_pix_inc = {1'b0, w_pix_base} + (CNT_WIDTH + 1)'(1);

  assign o_eof       = i_beat & i_tlast & (w_line_base == i_height - CNT_WIDTH'(1));
  assign o_err_short = GEOM_CHECK & i_beat &  i_tlast & (w_pix_inc <  {1'b0, i_width});
  assign o_err_long  = GEOM_CHECK & i_beat & ~i_tlast & (w_pix_inc == {1'b0, i_width});

  // NOTE: registered state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge value of every other register.
  always_ff @(posedge aclk) begin
    if (areset || i_clear) begin
      r_pix  <= '0;
      r_line <= '0;
    end else if (i_beat) begin
      if (i_tlast) begin
        r_pix  <= '0;
        r_line <= o_eof ? '0 : sat_inc(w_line_base);
      end else begin
        r_pix  <= sat_inc(w_pix_base);
        r_line <= w_line_base;
      end
    end
  end

endmodule

// File: rtl/cam_frame_ctrl.sv
// ----------------------------------------------------------------------------
// cam_frame_ctrl
// Frame-aligned capture gate between a CameraLink AXI4-Stream receiver and a
// video consumer. Capture is armed by software, opens on an SOF beat and
// closes only on a completed frame (single, N-frame or continuous). The data
// path is purely combinational; state, counters and flags are registered.
// Optional geometry checking: define CAM_FRAME_CTRL_GEOM_CHECK_EN.
// Ports:
//   aclk, areset     : clock, synchronous active-high reset
//   s_axis           : stream from receiver (slave side)
//   m_axis           : gated stream to consumer (master side)
//   ctrl_start/stop  : one-cycle pulses; stop wins when both are high
//   ctrl_mode        : 0 single, 1 N-frame, 2 continuous, 3 as single
//   ctrl_nframes     : frames to capture in N-frame mode (0 behaves as 1)
//   cfg_width/height : pixels per line, lines per frame (0 behaves as 1)
//   busy             : controller not idle
//   frame_done       : pulse the cycle after a frame's final tlast
//   frame_count      : frames completed since the last start
//   err_*            : sticky geometry error flags
// ----------------------------------------------------------------------------
module cam_frame_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 12,
  parameter int FRM_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  cam_frame_ctrl_if.slave       s_axis,
  cam_frame_ctrl_if.master      m_axis,
  input  logic                  ctrl_start,
  input  logic                  ctrl_stop,
  input  logic [1:0]            ctrl_mode,
  input  logic [FRM_WIDTH-1:0]  ctrl_nframes,
  input  logic [CNT_WIDTH-1:0]  cfg_width,
  input  logic [CNT_WIDTH-1:0]  cfg_height,
  output logic                  busy,
  output logic                  frame_done,
  output logic [FRM_WIDTH-1:0]  frame_count,
  output logic                  err_short_line,
  output logic                  err_long_line,
  output logic                  err_early_sof
);

  state_e                r_state;
  state_e                w_next_state;
  logic                  r_busy;
  logic                  r_frame_done;
  logic [FRM_WIDTH-1:0]  r_frame_count;
  logic                  r_stop_pending;
  logic [1:0]            r_mode;
  logic [FRM_WIDTH-1:0]  r_nframes;
  logic [CNT_WIDTH-1:0]  r_width;
  logic [CNT_WIDTH-1:0]  r_height;
  logic                  r_err_short;
  logic                  r_err_long;
  logic                  r_err_early;

  logic [DATA_WIDTH-1:0] w_tdata;
  logic [USER_WIDTH-1:0] w_tuser;
  logic                  w_sof;
  logic                  w_fwd;
  logic                  w_beat;
  logic                  w_start_take;
  logic                  w_eof;
  logic                  w_eof_beat;
  logic                  w_mode_done;
  logic                  w_exit;
  logic [FRM_WIDTH-1:0]  w_frame_next;
  logic                  w_sof_restart;
  logic                  w_err_short;
  logic                  w_err_long;
  logic                  w_err_early;

  function automatic logic [CNT_WIDTH-1:0] nz_cnt(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? CNT_WIDTH'(1) : v;
  endfunction

  // Sideband and payload always pass through untouched.
  assign w_tdata       = s_axis.tdata;
  assign w_tuser       = s_axis.tuser;
  assign m_axis.tdata  = w_tdata;
  assign m_axis.tuser  = w_tuser;
  assign m_axis.tlast  = s_axis.tlast;
  assign w_sof         = w_tuser[SOF_BIT];

  // Forwarding window: the whole of CAPTURE, plus the opening SOF beat while
  // ARMED. Outside it the upstream is drained (tready=1) and nothing is shown
  // downstream; reset closes the window in both directions.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    w_fwd = 1'b0;
    case (r_state)
      ARMED:   w_fwd = w_sof;
      CAPTURE: w_fwd = 1'b1;
      default: ;
    endcase
    if (areset) w_fwd = 1'b0;
  end

  assign m_axis.tvalid = w_fwd & s_axis.tvalid;
  assign s_axis.tready = areset ? 1'b0 : (w_fwd ? m_axis.tready : 1'b1);
  assign w_beat        = w_fwd & s_axis.tvalid & m_axis.tready;

  assign w_start_take  = (r_state == IDLE) & ctrl_start & ~ctrl_stop;
  assign w_eof_beat    = w_beat & w_eof;
  assign w_frame_next  = r_frame_count + FRM_WIDTH'(1);
  assign w_mode_done   = (r_mode == MODE_NFRAME) ? (w_frame_next == r_nframes)
                                                 : (r_mode != MODE_CONT);
  // A stop raised on the very beat that closes the frame is honoured too.
  assign w_exit        = w_eof_beat & (r_stop_pending | ctrl_stop | w_mode_done);

  cam_geom_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_geom (
    .aclk          (aclk),
    .areset        (areset),
    .i_clear       (w_start_take),
    .i_beat        (w_beat),
    .i_tlast       (s_axis.tlast),
    .i_sof         (w_sof),
    .i_first       (r_state == ARMED),
    .i_width       (r_width),
    .i_height      (r_height),
    .o_eof         (w_eof),
    .o_sof_restart (w_sof_restart),
    .o_err_short   (w_err_short),
    .o_err_long    (w_err_long),
    .o_err_early   (w_err_early)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_take) w_next_state = ARMED;
      end
      ARMED: begin
        if (ctrl_stop)   w_next_state = IDLE;
        else if (w_beat) w_next_state = w_exit ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        if (w_exit) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state        <= IDLE;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_count  <= '0;
      r_stop_pending <= 1'b0;
      r_mode         <= MODE_SINGLE;
      r_nframes      <= FRM_WIDTH'(1);
      r_width        <= CNT_WIDTH'(1);
      r_height       <= CNT_WIDTH'(1);
      r_err_short    <= 1'b0;
      r_err_long     <= 1'b0;
      r_err_early    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      // Registered from the next state so busy lines up with r_state.
      r_busy       <= (w_next_state != IDLE);
      r_frame_done <= w_eof_beat;

      if (w_start_take) begin
        r_mode        <= norm_mode(ctrl_mode);
        r_nframes     <= (ctrl_nframes == '0) ? FRM_WIDTH'(1) : ctrl_nframes;
        r_width       <= nz_cnt(cfg_width);
        r_height      <= nz_cnt(cfg_height);
        r_frame_count <= '0;
        r_err_short   <= 1'b0;
        r_err_long    <= 1'b0;
        r_err_early   <= 1'b0;
      end else begin
        // A restarted (aborted) frame never reaches eof on its own beats, so
        // only genuinely completed frames advance the count.
        if (w_eof_beat)  r_frame_count <= w_frame_next;
        if (w_err_short) r_err_short   <= 1'b1;
        if (w_err_long)  r_err_long    <= 1'b1;
        if (w_err_early || w_sof_restart) r_err_early <= 1'b1;
      end

      if (w_next_state == IDLE)
        r_stop_pending <= 1'b0;
      else if (r_state == CAPTURE && ctrl_stop)
        r_stop_pending <= 1'b1;
    end
  end

  assign busy           = r_busy;
  assign frame_done     = r_frame_done;
  assign frame_count    = r_frame_count;
  assign err_short_line = r_err_short;
  assign err_long_line  = r_err_long;
  assign err_early_sof  = r_err_early;

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cam_frame_ctrl
// Self-checking bench for cam_frame_ctrl. Stimulus frames are built as beat
// lists; the expected output is the list of whole frames that the capture
// mode entitles the consumer to see, plus frame count, frame_done pulses and
// error flags. Randomised valid/ready timing and geometry on top of the
// directed cases. Build with CAM_FRAME_CTRL_GEOM_CHECK_EN to expect flags.
// ----------------------------------------------------------------------------
module tb_cam_frame_ctrl;
  import cam_ctrl_pkg::*;

  localparam int DW = 24;
  localparam int UW = 1;
  localparam int CW = 12;
  localparam int FW = 16;

  typedef logic [DW+UW:0] beat_t;   // {tuser, tlast, tdata}

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          ctrl_start = 1'b0;
  logic          ctrl_stop = 1'b0;
  logic [1:0]    ctrl_mode = 2'd0;
  logic [FW-1:0] ctrl_nframes = '0;
  logic [CW-1:0] cfg_width = '0;
  logic [CW-1:0] cfg_height = '0;
  logic          busy;
  logic          frame_done;
  logic [FW-1:0] frame_count;
  logic          err_short_line;
  logic          err_long_line;
  logic          err_early_sof;

  cam_frame_ctrl_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
  cam_frame_ctrl_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();

  always #5 aclk = ~aclk;

  cam_frame_ctrl #(
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .CNT_WIDTH  (CW),
    .FRM_WIDTH  (FW)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .ctrl_start     (ctrl_start),
    .ctrl_stop      (ctrl_stop),
    .ctrl_mode      (ctrl_mode),
    .ctrl_nframes   (ctrl_nframes),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_count    (frame_count),
    .err_short_line (err_short_line),
    .err_long_line  (err_long_line),
    .err_early_sof  (err_early_sof)
  );

  int    n_checks = 0;
  int    n_fail = 0;
  beat_t src_q[$];
  beat_t exp_q[$];
  beat_t rcv_q[$];
  int    done_cnt = 0;
  int    gate_viol = 0;
  int    ready_mode = 0;
  logic  src_pop = 1'b0;

`ifdef CAM_FRAME_CTRL_GEOM_CHECK_EN
  localparam logic [2:0] MALFORMED_FLAGS = 3'b111;
`else
  localparam logic [2:0] MALFORMED_FLAGS = 3'b000;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  // Source driver: keeps tvalid up until the beat is taken, random gaps otherwise.
  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (src_pop && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() == 0)                s_if.tvalid = 1'b0;
      else if (!s_if.tvalid || src_pop)     s_if.tvalid = ($urandom_range(0, 3) != 0);
      if (src_q.size() > 0) {s_if.tuser, s_if.tlast, s_if.tdata} = src_q[0];
      case (ready_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = ~m_if.tready;
        default: m_if.tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor, sampled mid-cycle: handshakes, frame_done pulses, gating rules.
  always @(negedge aclk) begin
    src_pop = s_if.tvalid && s_if.tready;
    if (m_if.tvalid && m_if.tready) rcv_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
    if (frame_done) done_cnt++;
    if (!areset) begin
      if (m_if.tvalid && (s_if.tready !== m_if.tready)) gate_viol++;
      if (!busy && (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0)) gate_viol++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic beat_t mk_beat(input bit sof, input bit last);
    beat_t b;
    b = {sof, last, DW'($urandom)};
    return b;
  endfunction

  task automatic push_beat(input bit sof, input bit last, input bit expect_fwd);
    beat_t b;
    b = mk_beat(sof, last);
    src_q.push_back(b);
    if (expect_fwd) exp_q.push_back(b);
  endtask

  task automatic push_frame(input int w, input int h, input bit expect_fwd);
    for (int l = 0; l < h; l++)
      for (int p = 0; p < w; p++)
        push_beat(l == 0 && p == 0, p == w - 1, expect_fwd);
  endtask

  task automatic start_capture(input string tag, input int mode, input int nfr,
                               input int w, input int h);
    rcv_q.delete();
    exp_q.delete();
    done_cnt  = 0;
    gate_viol = 0;
    ctrl_mode    = 2'(mode);
    ctrl_nframes = FW'(nfr);
    cfg_width    = CW'(w);
    cfg_height   = CW'(h);
    ctrl_start   = 1'b1;
    tick();
    ctrl_start   = 1'b0;
    check({tag, ":busy_armed"}, busy, 1);
    check({tag, ":count_cleared"}, frame_count, 0);
  endtask

  task automatic wait_rcv(input string tag, input int target);
    int t;
    t = 0;
    while (rcv_q.size() != target && t < 5000) begin tick(); t++; end
    check({tag, ":wait_rcv_timeout"}, (t >= 5000), 0);
  endtask

  task automatic finish_capture(input string tag, input int nexp, input logic [2:0] exp_flags);
    int t;
    t = 0;
    while ((src_q.size() != 0 || busy) && t < 5000) begin tick(); t++; end
    check({tag, ":idle_timeout"}, (t >= 5000), 0);
    repeat (3) tick();
    check({tag, ":n_beats"}, rcv_q.size(), exp_q.size());
    for (int i = 0; i < rcv_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s:beat%0d", tag, i), rcv_q[i], exp_q[i]);
      if (rcv_q[i] !== exp_q[i]) break;
    end
    check({tag, ":frame_count"}, frame_count, nexp);
    check({tag, ":frame_done_pulses"}, done_cnt, nexp);
    check({tag, ":flags"}, {err_early_sof, err_long_line, err_short_line}, exp_flags);
    check({tag, ":gate_rules"}, gate_viol, 0);
    check({tag, ":busy_end"}, busy, 0);
  endtask

  // Well-formed traffic: junk before start (dropped in IDLE), junk after start
  // (dropped while ARMED), then frames of which only the entitled ones appear.
  task automatic run_scenario(input string tag, input int mode, input int nfr,
                              input int w, input int h, input int n_pre, input int n_junk,
                              input int rmode, input int stop_frame, input int stop_off);
    int nexp;
    int t;
    ready_mode = rmode;
    if (mode == 1)      nexp = (nfr == 0) ? 1 : nfr;
    else if (mode == 2) nexp = stop_frame + 1;
    else                nexp = 1;
    for (int i = 0; i < n_pre; i++) src_q.push_back(mk_beat(i == 0, $urandom_range(0, 1)));
    t = 0;
    while (src_q.size() != 0 && t < 2000) begin tick(); t++; end
    check({tag, ":pre_drain"}, src_q.size(), 0);
    start_capture(tag, mode, nfr, w, h);
    for (int i = 0; i < n_junk; i++) push_beat(1'b0, $urandom_range(0, 1), 1'b0);
    for (int f = 0; f < nexp + 1; f++) push_frame(w, h, f < nexp);
    if (stop_frame >= 0) begin
      wait_rcv(tag, stop_frame * w * h + stop_off);
      ctrl_stop = 1'b1;
      tick();
      ctrl_stop = 1'b0;
    end
    finish_capture(tag, nexp, 3'b000);
  endtask

  initial begin
    repeat (4) tick();
    check("rst:busy", busy, 0);
    check("rst:frame_done", frame_done, 0);
    check("rst:frame_count", frame_count, 0);
    check("rst:flags", {err_early_sof, err_long_line, err_short_line}, 0);
    check("rst:s_tready", s_if.tready, 0);
    check("rst:m_tvalid", m_if.tvalid, 0);
    areset = 1'b0;
    tick();
    check("rst_rel:s_tready", s_if.tready, 1);

    // Single shot 4x3, started in the middle of someone else's frame.
    run_scenario("single", 0, 0, 4, 3, 3, 5, 0, -1, 0);
    // N-frame, three 2x2 frames, consumer ready toggling every cycle.
    run_scenario("nframe3", 1, 3, 2, 2, 0, 2, 1, -1, 0);
    // Continuous 4x3, stop on pixel 2 of line 1: frame completes, next is dropped.
    run_scenario("cont_stop", 2, 0, 4, 3, 0, 1, 0, 0, 6);

    for (int k = 0; k < 8; k++) begin
      int m, w, h, fs;
      m  = $urandom_range(0, 3);
      w  = $urandom_range(2, 5);
      h  = $urandom_range(2, 4);
      fs = w * h;
      run_scenario($sformatf("rnd%0d_m%0d", k, m), m, $urandom_range(0, 4), w, h,
                   $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2),
                   (m == 2) ? $urandom_range(0, 2) : -1, $urandom_range(1, fs - 2));
    end

    // Malformed 4x2 stream in N-frame(2): short line, long line, then a
    // mid-frame SOF. Both builds forward the same beats and finish two frames.
    ready_mode = 0;
    start_capture("malformed", 1, 2, 4, 2);
    push_beat(1, 0, 1); push_beat(0, 0, 1); push_beat(0, 1, 1);
    for (int p = 0; p < 5; p++) push_beat(0, p == 4, 1);
    push_beat(1, 0, 1); push_beat(0, 0, 1); push_beat(1, 0, 1);
    push_beat(0, 0, 1); push_beat(0, 0, 1); push_beat(0, 1, 1);
    for (int p = 0; p < 4; p++) push_beat(0, p == 3, 1);
    push_frame(4, 2, 1'b0);
    finish_capture("malformed", 2, MALFORMED_FLAGS);

    // Reset in the middle of a line of the second continuous frame.
    ready_mode = 0;
    start_capture("reset", 2, 0, 4, 3);
    for (int f = 0; f < 3; f++) push_frame(4, 3, 1'b0);
    wait_rcv("reset", 12 + 5);
    check("reset:count_before", frame_count, 1);
    areset = 1'b1;
    @(negedge aclk);
    check("reset:s_tready_held", s_if.tready, 0);
    check("reset:m_tvalid_held", m_if.tvalid, 0);
    tick();
    check("reset:busy", busy, 0);
    check("reset:frame_count", frame_count, 0);
    check("reset:flags", {err_early_sof, err_long_line, err_short_line}, 0);
    src_q.delete();
    tick();
    check("reset:s_tready_held2", s_if.tready, 0);
    areset = 1'b0;
    @(negedge aclk);
    check("reset:s_tready_rel", s_if.tready, 1);
    check("reset:m_tvalid_rel", m_if.tvalid, 0);
    tick();

    // Start and stop together in IDLE: stop wins.
    ctrl_start = 1'b1;
    ctrl_stop  = 1'b1;
    tick();
    ctrl_start = 1'b0;
    ctrl_stop  = 1'b0;
    check("startstop:busy", busy, 0);
    tick();
    check("startstop:busy2", busy, 0);

    // Stop while ARMED returns to IDLE on the next cycle.
    start_capture("armed_stop", 0, 0, 4, 3);
    ctrl_stop = 1'b1;
    tick();
    ctrl_stop = 1'b0;
    check("armed_stop:busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
